// File: rtl/mul_share_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
// Operand and result stage records carry a 3-bit requester tag so the
// same types serve every NREQ up to MAX_NREQ.
package mul_share_pkg;

   localparam int OPW      = 16;
   localparam int PRODW    = 32;
   localparam int MAX_NREQ = 8;
   localparam int MAX_IDW  = 3;

   typedef struct packed {
      logic [OPW-1:0]     x;
      logic [OPW-1:0]     y;
      logic [MAX_IDW-1:0] id;
      logic               v;
   } op_t;

   typedef struct packed {
      logic [PRODW-1:0]   z;
      logic [MAX_IDW-1:0] id;
      logic               v;
   } rsp_t;

   // Index following idx in a ring of n slots.
   function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mul_share_arb_rr_picker.sv
// Combinational round-robin picker: starting at ptr, selects the first
// set request bit (wrapping modulo N). Returns a one-hot grant, its
// encoded index and a flag telling whether anything was granted.
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] pos;

   // Scan the ring from ptr and keep the first requester found.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = IW'((int'(ptr) + k) % N);
         if (!any && req[pos]) begin
            grant[pos] = 1'b1;
            idx        = pos;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multiplier16b.sv
// Unsigned 16x16 combinational multiplier giving a full 32-bit product.
module multiplier16b (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);

   assign p = 32'(a) * 32'(b);

endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: shares one multiplier16b between NREQ requesters.
// Round-robin arbitration, registered operands (S1), registered result (S2)
// tagged with the requester ID, per-requester valid/ready response channels.
// Optional build macro MUL_SHARE_ARB_RETIME_EN adds a third result register
// (S3) after S2; responses then leave from S3 one cycle later. The port list
// is the same in both builds.
module mul_share_arb
   import mul_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*16-1:0]  req_x,
   input  logic [NREQ*16-1:0]  req_y,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [31:0]         rsp_z,
   output logic                busy,
   output logic [15:0]         ops_cnt
);

   op_t              s1_reg;
   rsp_t             s2_reg;
   rsp_t             out_stage;
   logic [IDW-1:0]   ptr_reg;
   logic [IDW-1:0]   ptr_next;
   logic [IDW-1:0]   grant_idx;
   logic [NREQ-1:0]  grant;
   logic             grant_any;
   logic [OPW-1:0]   x_masked [NREQ];
   logic [OPW-1:0]   y_masked [NREQ];
   logic [OPW-1:0]   x_sel;
   logic [OPW-1:0]   y_sel;
   logic [PRODW-1:0] mul_p;
   logic [IDW-1:0]   out_id;
   logic             rsp_fire;
   logic             s2_leave;
   logic             s2_free;
   logic             s1_adv;
   logic             can_accept;
   logic             accept;
   logic [15:0]      ops_cnt_reg;
   logic             unused_id_hi;

   rr_picker #(
      .N  (NREQ),
      .IW (IDW)
   ) u_picker (
      .req   (req_valid),
      .ptr   (ptr_reg),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   multiplier16b u_mul (
      .a (s1_reg.x),
      .b (s1_reg.y),
      .p (mul_p)
   );

`ifdef MUL_SHARE_ARB_RETIME_EN
   rsp_t s3_reg;
   logic s3_free;

   assign out_stage = s3_reg;
   assign s3_free   = !s3_reg.v | rsp_fire;
   assign s2_leave  = s2_reg.v & s3_free;
   assign busy      = s1_reg.v | s2_reg.v | s3_reg.v;

   // S3 output register: takes S2 when it advances, empties on response transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_reg <= '0;
      end else if (s2_leave) begin
         s3_reg <= s2_reg;
      end else if (rsp_fire) begin
         s3_reg <= '0;
      end
   end
`else
   assign out_stage = s2_reg;
   assign s2_leave  = rsp_fire;
   assign busy      = s1_reg.v | s2_reg.v;
`endif

   // Stall chain: a stage may move only when the one after it frees up.
   assign out_id     = out_stage.id[IDW-1:0];
   assign rsp_fire   = out_stage.v & rsp_ready[out_id];
   assign s2_free    = !s2_reg.v | s2_leave;
   assign s1_adv     = s1_reg.v & s2_free;
   assign can_accept = !s1_reg.v | s1_adv;

   // Nothing is accepted while reset is held, even though the stages are empty.
   assign accept     = grant_any & can_accept & rst_n;
   assign req_ready  = grant & {NREQ{can_accept & rst_n}};
   assign ptr_next   = IDW'(wrap_next(32'(grant_idx), NREQ));

   assign rsp_z        = out_stage.z;
   assign ops_cnt      = ops_cnt_reg;
   assign unused_id_hi = ^out_stage.id;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign x_masked[gi]  = req_x[gi*OPW +: OPW] & {OPW{grant[gi]}};
      assign y_masked[gi]  = req_y[gi*OPW +: OPW] & {OPW{grant[gi]}};
      assign rsp_valid[gi] = out_stage.v & (out_id == IDW'(gi));
   end

   // OR together the operand slices masked by the one-hot grant.
   always_comb begin
      x_sel = '0;
      y_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         x_sel = x_sel | x_masked[i];
         y_sel = y_sel | y_masked[i];
      end
   end

   // S1 operand register: loads on accept, empties when it advances alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_reg <= '0;
      end else if (accept) begin
         s1_reg.x  <= x_sel;
         s1_reg.y  <= y_sel;
         s1_reg.id <= 3'(grant_idx);
         s1_reg.v  <= 1'b1;
      end else if (s1_adv) begin
         s1_reg.v <= 1'b0;
      end
   end

   // S2 result register: captures the product; zeroed when it drains empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_reg <= '0;
      end else if (s1_adv) begin
         s2_reg.z  <= mul_p;
         s2_reg.id <= s1_reg.id;
         s2_reg.v  <= 1'b1;
      end else if (s2_leave) begin
         s2_reg <= '0;
      end
   end

   // Round-robin pointer moves past the winner only when a request transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else if (accept) begin
         ptr_reg <= ptr_next;
      end
   end

   // Completed-operation counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops_cnt_reg <= '0;
      end else if (rsp_fire) begin
         ops_cnt_reg <= ops_cnt_reg + 16'd1;
      end
   end

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: scoreboard of expected products
// pushed at request transfer and popped at response transfer.
module tb_mul_share_arb;

   localparam int NREQ = 4;
`ifdef MUL_SHARE_ARB_RETIME_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*16-1:0]  req_x;
   logic [NREQ*16-1:0]  req_y;
   logic [NREQ-1:0]     rsp_valid;
   logic [NREQ-1:0]     rsp_ready;
   logic [31:0]         rsp_z;
   logic                busy;
   logic [15:0]         ops_cnt;

   mul_share_arb #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_z     (rsp_z),
      .busy      (busy),
      .ops_cnt   (ops_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] z;
      int          cyc;
   } sb_t;

   int          checks = 0;
   int          failures = 0;
   sb_t         sb[$];
   logic [15:0] op_x [NREQ][16];
   logic [15:0] op_y [NREQ][16];
   int          head [NREQ];
   int          tail [NREQ];
   int          gnt_id[$];
   int          gnt_cyc[$];
   int          rsp_cyc[$];
   logic [31:0] z_log[$];
   int          cyc = 0;
   int          busy_cnt = 0;
   int          stall1_cnt = 0;
   int          ops_model = 0;
   bit          chk_lat = 0;
   bit          head_seen = 0;
   bit          stall_prev = 0;
   bit          rdy_low_seen = 0;
   logic [31:0] prev_z;
   logic [NREQ-1:0] prev_v;
   logic [NREQ-1:0] rq_fire = '0;
   logic [NREQ-1:0] rdy_mask = '1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic enqueue(input int id, input logic [15:0] x, input logic [15:0] y);
      op_x[id][tail[id]] = x;
      op_y[id][tail[id]] = y;
      tail[id]++;
   endtask

   function automatic bit pending();
      for (int i = 0; i < NREQ; i++)
         if (head[i] < tail[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Observe handshakes at the falling edge; they take effect at the next rising edge.
   task automatic evaluate();
      sb_t e;
      logic [NREQ-1:0] rfire;
      if (busy) busy_cnt++;
      check("rdy_onehot0", 32'($onehot0(req_ready)), 32'd1);
      check("ops_cnt", 32'(ops_cnt), 32'(ops_model));
      rq_fire = req_valid & req_ready;
      if (req_valid != '0 && req_ready == '0) rdy_low_seen = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         if (rq_fire[i]) begin
            e.id  = i;
            e.z   = 32'(op_x[i][head[i]]) * 32'(op_y[i][head[i]]);
            e.cyc = cyc;
            sb.push_back(e);
            gnt_id.push_back(i);
            gnt_cyc.push_back(cyc);
            $display("req id=%0d x=0x%04h y=0x%04h cycle=%0d", i, op_x[i][head[i]], op_y[i][head[i]], cyc);
         end
      end
      rfire = rsp_valid & rsp_ready;
      if (rsp_valid != '0) begin
         if (stall_prev) begin
            check("hold_z", rsp_z, prev_z);
            check("hold_valid", 32'(rsp_valid), 32'(prev_v));
         end
         if (sb.size() == 0) begin
            check("spurious_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            e = sb[0];
            check("rsp_owner", 32'(rsp_valid), 32'd1 << e.id);
            check("rsp_z", rsp_z, e.z);
            if (chk_lat && !head_seen) check("latency", 32'(cyc - e.cyc), 32'(LAT));
            head_seen = 1'b1;
            if (rfire != '0) begin
               void'(sb.pop_front());
               head_seen = 1'b0;
               ops_model++;
               z_log.push_back(rsp_z);
               rsp_cyc.push_back(cyc);
               $display("rsp id=%0d z=0x%08h cycle=%0d", e.id, rsp_z, cyc);
            end
         end
         if (rsp_valid[1] && !rsp_ready[1]) stall1_cnt++;
         stall_prev = (rfire == '0);
         prev_z     = rsp_z;
         prev_v     = rsp_valid;
      end else begin
         check("idle_z", rsp_z, 32'd0);
         stall_prev = 1'b0;
      end
   endtask

   // Present the next operand per requester just after the rising edge.
   task automatic drive();
      for (int i = 0; i < NREQ; i++)
         if (rq_fire[i]) head[i]++;
      rq_fire = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = (head[i] < tail[i]);
         if (head[i] < tail[i]) begin
            req_x[i*16 +: 16] = op_x[i][head[i]];
            req_y[i*16 +: 16] = op_y[i][head[i]];
         end
      end
      rsp_ready = rdy_mask;
   endtask

   task automatic cycle();
      @(negedge clk);
      cyc++;
      evaluate();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      sb.delete();
      head_seen  = 1'b0;
      stall_prev = 1'b0;
      ops_model  = 0;
      rq_fire    = '0;
      for (int i = 0; i < NREQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_idle(input int max_cyc);
      int n;
      n = 0;
      while ((pending() || sb.size() != 0) && n < max_cyc) begin
         cycle();
         n++;
      end
      check("drained", 32'(sb.size()) + 32'(pending()), 32'd0);
      repeat (2) cycle();
      check("idle_busy", 32'(busy), 32'd0);
      check("ops_cnt_end", 32'(ops_cnt), 32'(ops_model));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < NREQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      rsp_ready = '1;
      req_valid = '1;
      req_x     = {NREQ{16'h1111}};
      req_y     = {NREQ{16'h2222}};

      // Reset state while every requester is asking.
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_z", rsp_z, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ops_cnt", 32'(ops_cnt), 32'd0);
      do_reset();

      // Reset mid-operation discards the in-flight op.
      gnt_id.delete();
      enqueue(2, 16'd3, 16'd5);
      n = 0;
      while (gnt_id.size() == 0 && n < 10) begin
         cycle();
         n++;
      end
      check("midop_accepted", 32'(gnt_id.size()), 32'd1);
      check("midop_busy", 32'(busy), 32'd1);
      do_reset();
      repeat (6) cycle();
      check("midop_ops_cnt", 32'(ops_cnt), 32'd0);
      check("midop_busy_after", 32'(busy), 32'd0);

      // Single operation: latency, product, busy span.
      do_reset();
      chk_lat  = 1'b1;
      busy_cnt = 0;
      z_log.delete();
      enqueue(0, 16'h1234, 16'h0010);
      run_idle(20);
      check("single_count", 32'(z_log.size()), 32'd1);
      check("single_z", z_log[0], 32'h00012340);
      check("single_ops", 32'(ops_cnt), 32'd1);
      check("single_busy_cycles", 32'(busy_cnt), 32'(LAT));

      // Operand extremes.
      z_log.delete();
      enqueue(3, 16'hFFFF, 16'hFFFF);
      enqueue(3, 16'h0000, 16'hABCD);
      run_idle(20);
      check("ext_count", 32'(z_log.size()), 32'd2);
      check("ext_max", z_log[0], 32'hFFFE0001);
      check("ext_zero", z_log[1], 32'd0);

      // Round-robin fairness with all requesters streaming.
      do_reset();
      gnt_id.delete();
      gnt_cyc.delete();
      rsp_cyc.delete();
      for (int r = 0; r < 4; r++)
         for (int i = 0; i < NREQ; i++)
            enqueue(i, 16'($urandom), 16'($urandom));
      run_idle(100);
      check("rr_grants", 32'(gnt_id.size()), 32'd16);
      for (int k = 0; k < gnt_id.size(); k++) begin
         check("rr_order", 32'(gnt_id[k]), 32'(k % NREQ));
         if (k > 0) check("rr_rate", 32'(gnt_cyc[k] - gnt_cyc[k-1]), 32'd1);
      end
      check("rr_rsp_count", 32'(rsp_cyc.size()), 32'd16);
      for (int k = 1; k < rsp_cyc.size(); k++)
         check("rr_rsp_rate", 32'(rsp_cyc[k] - rsp_cyc[k-1]), 32'd1);

      // Backpressure on requester 1 while 1 and 2 stream.
      chk_lat  = 1'b0;
      rdy_mask = 4'b1101;
      do_reset();
      stall1_cnt   = 0;
      rdy_low_seen = 1'b0;
      rsp_cyc.delete();
      for (int r = 0; r < 3; r++) begin
         enqueue(1, 16'($urandom), 16'($urandom));
         enqueue(2, 16'($urandom), 16'($urandom));
      end
      n = 0;
      while (stall1_cnt < 5 && n < 30) begin
         cycle();
         n++;
      end
      check("bp_stalled", 32'(stall1_cnt), 32'd5);
      check("bp_ready_low", 32'(rdy_low_seen), 32'd1);
      check("bp_no_rsp_yet", 32'(rsp_cyc.size()), 32'd0);
      rdy_mask  = '1;
      rsp_ready = rdy_mask;
      run_idle(50);
      check("bp_rsp_count", 32'(rsp_cyc.size()), 32'd6);
      check("bp_release_b2b", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
